bch_chien_search: RTL and testbench

BCH_CHIEN_SEARCH -- requirements
Module: bch_chien_search

---
 rtl/bch_pkg.sv | 80 ++++++++
 rtl/bch_chien_cell.sv | 30 +++
 rtl/bch_chien_search.sv | 118 +++++++++++
 tb/tb_bch_chien_search.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bch_pkg.sv
// Shared GF(2^M) helpers and FSM state type for the
// BCH Chien search block.
package bch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  function automatic logic [16:0] prim_poly(input int m);
    logic [16:0] p;
    case (m)
      2:       p = 17'h00007;
      3:       p = 17'h0000b;
      4:       p = 17'h00013;
      5:       p = 17'h00025;
      6:       p = 17'h00043;
      7:       p = 17'h00089;
      8:       p = 17'h0011d;
      9:       p = 17'h00211;
      10:      p = 17'h00409;
      11:      p = 17'h00805;
      12:      p = 17'h01053;
      13:      p = 17'h0201b;
      14:      p = 17'h04443;
      15:      p = 17'h08003;
      16:      p = 17'h1100b;
      default: p = 17'h00013;
    endcase
    return p;
  endfunction

  // Shift-and-add multiply, MSB of b first.
  function automatic logic [15:0] gf_mult(
    input logic [15:0] a,
    input logic [15:0] b,
    input int          m
  );
    logic [16:0] r;
    logic [16:0] poly;
    poly = prim_poly(m);
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (i < m) begin
        r = {r[15:0], 1'b0};
        if (r[m]) r = r ^ poly;
        if (b[i]) r = r ^ {1'b0, a};
      end
    end
    return r[15:0];
  endfunction

  function automatic logic [15:0] gf_pow(
    input int e,
    input int m
  );
    logic [15:0] r;
    int q;
    int ee;
    q  = (1 << m) - 1;
    ee = e % q;
    r  = 16'h1;
    for (int i = 15; i >= 0; i--) begin
      r = gf_mult(r, r, m);
      if (ee[i]) r = gf_mult(r, 16'h2, m);
    end
    return r;
  endfunction

  function automatic logic [15:0] alpha_neg(
    input int e,
    input int m
  );
    int q;
    q = (1 << m) - 1;
    return gf_pow((q - (e % q)) % q, m);
  endfunction

endpackage

// File: rtl/bch_chien_cell.sv
// One Chien lane: evaluates the locator at offset K
// from the current register point and flags a root.
module bch_chien_cell
  import bch_pkg::*;
#(
  parameter int M = 4,
  parameter int T = 2,
  parameter int K = 0
) (
  input  logic [T*M-1:0] r,
  output logic           zero
);

  logic [15:0] term [T];

  for (genvar j = 1; j <= T; j++) begin : g_term
    localparam logic [15:0] C = alpha_neg(j * K, M);
    assign term[j-1] =
      gf_mult(16'(r[j*M-1 -: M]), C, M);
  end

  logic [15:0] s;

  always_comb begin
    s = 16'h1;
    for (int j = 0; j < T; j++) s = s ^ term[j];
    zero = (s == 16'h0);
  end

endmodule

// File: rtl/bch_chien_search.sv
// Chien search: P roots per cycle over N positions,
// registered error vector, count and degree check.
module bch_chien_search
  import bch_pkg::*;
#(
  parameter int M = 4,
  parameter int T = 2,
  parameter int N = 15,
  parameter int P = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [T*M-1:0]           lambda_i,
  input  logic [$clog2(T+1)-1:0]   deg_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output logic [N-1:0]             error_vector_o,
  output logic [$clog2(N+1)-1:0]   err_count_o,
  output logic                     fail_o
);

  localparam int C  = N / P;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int DW = $clog2(T + 1);
  localparam int EW = $clog2(N + 1);

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   deg_q;
  logic [T*M-1:0]  r;
  logic [T*M-1:0]  r_step;
  logic [P-1:0]    zero;
  logic [N-1:0]    ev_n;
  logic [EW-1:0]   hits;

  for (genvar k = 0; k < P; k++) begin : g_lane
    bch_chien_cell #(
      .M(M),
      .T(T),
      .K(k)
    ) u_cell (
      .r    (r),
      .zero (zero[k])
    );
  end

  // Advance every coefficient by P positions per cycle.
  for (genvar j = 1; j <= T; j++) begin : g_step
    localparam logic [15:0] S = alpha_neg(j * P, M);
    assign r_step[j*M-1 -: M] =
      M'(gf_mult(16'(r[j*M-1 -: M]), S, M));
  end

  always_comb begin
    ev_n = error_vector_o;
    hits = '0;
    for (int k = 0; k < P; k++) begin
      if (zero[k]) begin
        ev_n[int'(cnt) * P + k] = 1'b1;
        hits = hits + EW'(1);
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start_i) state_n = SEARCH;
      SEARCH:  if (cnt == CW'(C - 1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign ready_o = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      r              <= '0;
      deg_q          <= '0;
      error_vector_o <= '0;
      err_count_o    <= '0;
      fail_o         <= 1'b0;
      valid_o        <= 1'b0;
    end else begin
      state   <= state_n;
      valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            deg_q          <= deg_i;
            r              <= lambda_i;
            error_vector_o <= '0;
            err_count_o    <= '0;
            fail_o         <= 1'b0;
            cnt            <= '0;
          end
        end
        SEARCH: begin
          r              <= r_step;
          error_vector_o <= ev_n;
          err_count_o    <= err_count_o + hits;
          if (cnt != CW'(C - 1)) cnt <= cnt + CW'(1);
        end
        DONE: begin
          valid_o <= 1'b1;
          fail_o  <= (int'(err_count_o) != int'(deg_q));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_chien_search.sv
// Directed bench for bch_chien_search, GF(16),
// run on a P=1 and a P=5 instance side by side.
module tb_bch_chien_search;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [7:0]  lambda;
  logic [1:0]  deg;

  logic        ready1, valid1, fail1;
  logic [14:0] ev1;
  logic [3:0]  cnt1;
  logic        ready5, valid5, fail5;
  logic [14:0] ev5;
  logic [3:0]  cnt5;

  bch_chien_search #(.M(4), .T(2), .N(15), .P(1)) u1 (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .lambda_i       (lambda),
    .deg_i          (deg),
    .ready_o        (ready1),
    .valid_o        (valid1),
    .error_vector_o (ev1),
    .err_count_o    (cnt1),
    .fail_o         (fail1)
  );

  bch_chien_search #(.M(4), .T(2), .N(15), .P(5)) u5 (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .lambda_i       (lambda),
    .deg_i          (deg),
    .ready_o        (ready5),
    .valid_o        (valid5),
    .error_vector_o (ev5),
    .err_count_o    (cnt5),
    .fail_o         (fail5)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h",
               name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  l1;
    logic [3:0]  l2;
    logic [1:0]  deg;
    logic [14:0] ev;
    logic [3:0]  cnt;
    logic        fail;
  } vec_t;

  vec_t vecs[8];

  int lat1, lat5, np1, np5;

  // Called just after a rising edge; start sampled at the next edge.
  task automatic launch(
    input logic [3:0] l1,
    input logic [3:0] l2,
    input logic [1:0] d
  );
    start  = 1'b1;
    lambda = {l2, l1};
    deg    = d;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic watch(input int ncyc);
    lat1 = -1;
    lat5 = -1;
    np1  = 0;
    np5  = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      if (valid1) begin
        np1++;
        if (lat1 < 0) lat1 = c;
      end
      if (valid5) begin
        np5++;
        if (lat5 < 0) lat5 = c;
      end
    end
  endtask

  task automatic check_res(input string tag, input vec_t v);
    check({tag, "_ev1"},   ev1,   v.ev);
    check({tag, "_cnt1"},  cnt1,  v.cnt);
    check({tag, "_fail1"}, fail1, v.fail);
    check({tag, "_ev5"},   ev5,   v.ev);
    check({tag, "_cnt5"},  cnt5,  v.cnt);
    check({tag, "_fail5"}, fail5, v.fail);
  endtask

  initial begin
    bit found;

    vecs[0] = '{4'h8, 4'h0, 2'd1, 15'h0008, 4'd1, 1'b0};
    vecs[1] = '{4'h7, 4'h6, 2'd2, 15'h0021, 4'd2, 1'b0};
    vecs[2] = '{4'h0, 4'h0, 2'd0, 15'h0000, 4'd0, 1'b0};
    vecs[3] = '{4'h0, 4'h1, 2'd2, 15'h0001, 4'd1, 1'b1};
    vecs[4] = '{4'h9, 4'h0, 2'd1, 15'h4000, 4'd1, 1'b0};
    vecs[5] = '{4'hf, 4'hd, 2'd2, 15'h0408, 4'd2, 1'b0};
    vecs[6] = '{4'h8, 4'h0, 2'd2, 15'h0008, 4'd1, 1'b1};
    vecs[7] = '{4'h0, 4'h0, 2'd1, 15'h0000, 4'd0, 1'b1};

    rst    = 1'b1;
    start  = 1'b1;
    lambda = 8'hff;
    deg    = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready1", ready1, 1'b1);
    check("rst_valid1", valid1, 1'b0);
    check("rst_ev1",    ev1,    15'h0);
    check("rst_cnt1",   cnt1,   4'd0);
    check("rst_fail1",  fail1,  1'b0);
    check("rst_ready5", ready5, 1'b1);
    check("rst_ev5",    ev5,    15'h0);
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].l1, vecs[i].l2, vecs[i].deg);
      check($sformatf("v%0d_busy1", i), ready1, 1'b0);
      check($sformatf("v%0d_busy5", i), ready5, 1'b0);
      watch(24);
      check($sformatf("v%0d_lat1", i), lat1, 16);
      check($sformatf("v%0d_lat5", i), lat5, 4);
      check($sformatf("v%0d_np1", i),  np1,  1);
      check($sformatf("v%0d_np5", i),  np5,  1);
      check_res($sformatf("v%0d", i), vecs[i]);
    end

    // start held high: later starts ignored until IDLE returns
    start  = 1'b1;
    lambda = {4'h0, 4'h8};
    deg    = 2'd1;
    watch(33);
    check("held_np1", np1, 1);
    check("held_np5", np5, 6);
    check("held_lat1", lat1, 17);
    start = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // reset in the middle of a search
    launch(4'h7, 4'h6, 2'd2);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("mid_pre_ev1", ev1, 15'h0001);
    check("mid_pre_ev5", ev5, 15'h0021);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_ready1", ready1, 1'b1);
    check("mid_ready5", ready5, 1'b1);
    check("mid_valid1", valid1, 1'b0);
    check("mid_ev1",    ev1,    15'h0);
    check("mid_cnt1",   cnt1,   4'd0);
    check("mid_ev5",    ev5,    15'h0);
    check("mid_cnt5",   cnt5,   4'd0);
    watch(24);
    check("mid_np1", np1, 0);
    check("mid_np5", np5, 0);

    // back-to-back: new start in the IDLE cycle carrying valid_o
    launch(4'h8, 4'h0, 2'd1);
    found = 1'b0;
    for (int c = 0; c < 24 && !found; c++) begin
      @(posedge clk);
      #1;
      if (valid1) found = 1'b1;
    end
    check("b2b_found", found, 1'b1);
    check("b2b_first_ev1", ev1, 15'h0008);
    check("b2b_ready1", ready1, 1'b1);
    launch(4'h7, 4'h6, 2'd2);
    check("b2b_clr_ev1",  ev1,    15'h0);
    check("b2b_clr_cnt1", cnt1,   4'd0);
    check("b2b_clr_ev5",  ev5,    15'h0);
    check("b2b_busy1",    ready1, 1'b0);
    watch(24);
    check("b2b_lat1", lat1, 16);
    check("b2b_np1",  np1,  1);
    check_res("b2b", vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
